// File: rtl/ramb4_s4_stream_reader.sv
// rtl/ramb4_s4_stream_reader.sv - streaming read initiator for the 4-bit port of a 1024x4 block RAM
// Defining RAMB4_RD_ABORT_EN adds an ABORT input that cancels a running transfer.
module ramb4_s4_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLKA,
  input  logic              RSTB,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LEN,
`ifdef RAMB4_RD_ABORT_EN
  input  logic              ABORT,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  input  logic [DATA_W-1:0] RAM_DO,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_V = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   out_left;
  logic              rd_v;
  logic              abort_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       occ;
  logic [PW:0]       occ_after_pop;
  logic [PW:0]       committed;
  logic              pop;
  logic              abort_req;
  logic              start_ok;

`ifdef RAMB4_RD_ABORT_EN
  assign abort_req = ABORT && BUSY && !abort_q;
`else
  assign abort_req = 1'b0;
`endif

  assign M_VALID = (occ != '0);
  assign pop     = M_VALID && M_READY;
  assign M_DATA  = M_VALID ? mem[rd_ptr] : '0;
  assign M_LAST  = M_VALID && (out_left == (ADDR_W+1)'(1));

  // Slots already promised: buffered words left after this cycle's pop plus the read in the RAM pipe.
  assign occ_after_pop = occ - {{PW{1'b0}}, pop};
  assign committed     = occ_after_pop + {{PW{1'b0}}, rd_v};

  assign RAM_EN   = (state == RUN) && !abort_req && (committed < DEPTH_V);
  assign RAM_ADDR = rd_addr;
  assign RAM_WE   = 1'b0;
  assign RAM_RST  = 1'b0;

  assign start_ok = (state == IDLE) && !BUSY && START && (LEN != '0);

  always_ff @(posedge CLKA) begin
    if (rd_v) mem[wr_ptr] <= RAM_DO;
  end

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state      <= IDLE;
      rd_addr    <= '0;
      issue_left <= '0;
      out_left   <= '0;
      rd_v       <= 1'b0;
      abort_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      abort_q <= 1'b0;
      rd_v    <= RAM_EN;
      occ     <= occ + {{PW{1'b0}}, rd_v} - {{PW{1'b0}}, pop};
      if (rd_v) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_left <= out_left - 1'b1;
      end
      if (RAM_EN) begin
        rd_addr    <= rd_addr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
      case (state)
        IDLE: if (start_ok) begin
          state      <= RUN;
          BUSY       <= 1'b1;
          rd_addr    <= BASE_ADDR;
          issue_left <= LEN;
          out_left   <= LEN;
        end
        RUN: if (RAM_EN && issue_left == (ADDR_W+1)'(1)) state <= DRAIN;
        DRAIN: if (pop && M_LAST && occ_after_pop == '0) begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (abort_q) begin
        BUSY <= 1'b0;
        DONE <= 1'b1;
      end
      // BUSY stays high for one flush cycle so DONE lands a cycle after M_VALID drops.
      if (abort_req) begin
        state    <= IDLE;
        abort_q  <= 1'b1;
        rd_v     <= 1'b0;
        occ      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        out_left <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ramb4_s4_stream_reader.sv
// tb/tb_ramb4_s4_stream_reader.sv - scoreboard bench for ramb4_s4_stream_reader
module tb_ramb4_s4_stream_reader;
  localparam int AW = 10;
  localparam int DW = 4;

  logic          CLKA = 1'b0;
  logic          RSTB = 1'b1;
  logic          START = 1'b0;
  logic [AW-1:0] BASE_ADDR = '0;
  logic [AW:0]   LEN = '0;
`ifdef RAMB4_RD_ABORT_EN
  logic          ABORT = 1'b0;
`endif
  logic          BUSY, DONE, RAM_EN, RAM_WE, RAM_RST, M_VALID, M_LAST;
  logic          M_READY = 1'b1;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DO = '0;
  logic [DW-1:0] M_DATA;
  logic [DW-1:0] ram [1024];

  ramb4_s4_stream_reader dut (
    .CLKA(CLKA), .RSTB(RSTB), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
`ifdef RAMB4_RD_ABORT_EN
    .ABORT(ABORT),
`endif
    .BUSY(BUSY), .DONE(DONE), .RAM_ADDR(RAM_ADDR), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE),
    .RAM_RST(RAM_RST), .RAM_DO(RAM_DO), .M_DATA(M_DATA), .M_VALID(M_VALID),
    .M_READY(M_READY), .M_LAST(M_LAST)
  );

  always #5 CLKA = ~CLKA;

  always @(posedge CLKA) if (RAM_EN) RAM_DO <= ram[RAM_ADDR];

  int vecs = 0, errs = 0, hs_cnt = 0, done_cnt = 0, last_cnt = 0, outstanding = 0, exp_done = 0;
  bit bad_we = 0, bad_issue = 0, done_due = 0, prev_stall = 0, log_addr = 0;
  bit bp_mode = 0, force_low = 0;
  logic [DW:0]   prev_word;
  logic [DW:0]   sb [$];
  logic [AW-1:0] addr_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKA); #1;
  endtask

  task automatic expect_words(input logic [AW-1:0] base, input int len, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      sb.push_back({(i == len - 1), a[3:0]});
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int len);
    BASE_ADDR = base;
    LEN = (AW+1)'(len);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    exp_done++;
    for (int k = 0; k < budget && done_cnt < exp_done; k++) tick();
    tick();
    check(name, done_cnt, exp_done);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_pops(input int target, input int budget);
    for (int k = 0; k < budget && hs_cnt < target; k++) tick();
    check("pop_count", hs_cnt, target);
  endtask

  // M_READY driver: steady high, 1-on/3-off pattern, or forced low.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge CLKA); #2;
      cyc++;
      M_READY = force_low ? 1'b0 : (bp_mode ? (cyc % 4 == 0) : 1'b1);
    end
  end

  // Monitor: scoreboard pops, stall stability, issue-limit model, DONE tracking.
  initial begin
    forever begin
      @(negedge CLKA);
      if (RSTB) begin
        prev_stall = 0;
        outstanding = 0;
        done_due = 0;
      end else begin
        if (RAM_WE !== 1'b0 || RAM_RST !== 1'b0) bad_we = 1;
        if (RAM_EN && (outstanding - int'(M_VALID && M_READY)) >= 4) bad_issue = 1;
        if (outstanding > 4) bad_issue = 1;
        if (DONE) done_cnt++;
        if (done_due) begin
          check("done_after_last", DONE, 1);
          check("busy_low_at_done", BUSY, 0);
          done_due = 0;
        end
        if (prev_stall) check("stall_hold", {M_VALID, M_LAST, M_DATA}, {1'b1, prev_word});
        if (RAM_EN && log_addr) addr_log.push_back(RAM_ADDR);
        if (RAM_EN) outstanding++;
        if (M_VALID && M_READY) begin
          hs_cnt++;
          outstanding--;
          if (M_LAST) begin
            last_cnt++;
            done_due = 1;
          end
          if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_word: got %0h expected no word", {M_LAST, M_DATA});
          end else begin
            check("word", {M_LAST, M_DATA}, sb.pop_front());
          end
        end
        prev_stall = M_VALID && !M_READY;
        prev_word = {M_LAST, M_DATA};
`ifdef RAMB4_RD_ABORT_EN
        if (ABORT && BUSY) begin
          outstanding = 0;
          prev_stall = 0;
        end
`endif
      end
    end
  end

  initial begin
    int lat;
    int h0;
    int l0;
    bit busy_seen;
    for (int i = 0; i < 1024; i++) ram[i] = DW'(i);
    RSTB = 1'b1;
    tick(); tick();
    RSTB = 1'b0;
    @(negedge CLKA);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ram_en", RAM_EN, 0);
    check("rst_ram_addr", RAM_ADDR, 0);
    check("rst_m_valid", M_VALID, 0);
    check("rst_m_last", M_LAST, 0);
    check("rst_m_data", M_DATA, 0);
    tick();

    // Basic 8-word transfer and first-word latency.
    expect_words(10'h010, 8, 8);
    pulse_start(10'h010, 8);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge CLKA);
      if (M_VALID) lat = k;
    end
    check("first_valid_latency", lat, 3);
    wait_done("basic_done", 50);

    // Address wrap at the top of the RAM.
    log_addr = 1;
    addr_log.delete();
    expect_words(10'h3FE, 4, 4);
    pulse_start(10'h3FE, 4);
    wait_done("wrap_done", 50);
    log_addr = 0;
    check("wrap_addr_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", addr_log[0], 10'h3FE);
      check("wrap_addr1", addr_log[1], 10'h3FF);
      check("wrap_addr2", addr_log[2], 10'h000);
      check("wrap_addr3", addr_log[3], 10'h001);
    end

    // Back-pressure with 1-on/3-off ready.
    bp_mode = 1;
    expect_words(10'h020, 16, 16);
    pulse_start(10'h020, 16);
    wait_done("bp_done", 400);
    bp_mode = 0;

    // START while busy is ignored; LEN=0 is ignored.
    expect_words(10'h040, 6, 6);
    pulse_start(10'h040, 6);
    tick();
    pulse_start(10'h100, 3);
    wait_done("busy_start_done", 60);
    pulse_start(10'h000, 0);
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (BUSY) busy_seen = 1;
      tick();
    end
    check("len0_busy", busy_seen, 0);
    check("len0_done_count", done_cnt, exp_done);

    // Reset after five words of a 20-word transfer.
    expect_words(10'h000, 20, 5);
    h0 = hs_cnt;
    pulse_start(10'h000, 20);
    wait_pops(h0 + 5, 100);
    RSTB = 1'b1;
    force_low = 1;
    tick();
    RSTB = 1'b0;
    force_low = 0;
    @(negedge CLKA);
    check("rst_mid_m_valid", M_VALID, 0);
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_ram_en", RAM_EN, 0);
    check("rst_mid_sb_empty", sb.size(), 0);
    tick(); tick(); tick();
    check("rst_mid_no_done", done_cnt, exp_done);
    expect_words(10'h050, 2, 2);
    pulse_start(10'h050, 2);
    wait_done("post_rst_done", 50);

`ifdef RAMB4_RD_ABORT_EN
    // Abort after three words of a 10-word transfer.
    l0 = last_cnt;
    expect_words(10'h060, 10, 3);
    h0 = hs_cnt;
    pulse_start(10'h060, 10);
    wait_pops(h0 + 3, 100);
    ABORT = 1'b1;
    force_low = 1;
    tick();
    ABORT = 1'b0;
    @(negedge CLKA);
    check("abort_m_valid", M_VALID, 0);
    check("abort_done_early", DONE, 0);
    @(negedge CLKA);
    check("abort_done", DONE, 1);
    force_low = 0;
    exp_done++;
    tick(); tick();
    check("abort_done_count", done_cnt, exp_done);
    check("abort_no_last", last_cnt, l0);
    check("abort_sb_empty", sb.size(), 0);
`else
    l0 = 0;
`endif

    // Single word, then a full 1024-word sweep.
    expect_words(10'h3FF, 1, 1);
    pulse_start(10'h3FF, 1);
    wait_done("len1_done", 30);
    expect_words(10'h200, 1024, 1024);
    pulse_start(10'h200, 1024);
    wait_done("full_done", 1200);

    check("ram_we_rst_zero", bad_we, 0);
    check("issue_limit", bad_issue, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
